// File: rtl/easy_driver_step_gen.sv
// easy_driver_step_gen: Avalon-MM programmed STEP/DIR/ENABLE generator
// for one EasyDriver axis, with position tracking and abort.
module easy_driver_step_gen #(
  parameter int PERIOD_W      = 24,
  parameter int DEF_HALF_PER  = 2500,
  parameter int DIR_SETUP_CYC = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        step,
  output logic        dir,
  output logic        enable
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    HI,
    LO
  } state_t;

  localparam logic [PERIOD_W-1:0] SETUP_LAST =
    PERIOD_W'(DIR_SETUP_CYC - 1);
  localparam logic [PERIOD_W-1:0] PER_RST = PERIOD_W'(DEF_HALF_PER);
  localparam logic [PERIOD_W-1:0] PER_MIN = PERIOD_W'(2);

  state_t              state_q;
  logic                ctrl_en_q;
  logic                ctrl_dir_q;
  logic                dir_q;
  logic                step_q;
  logic                done_q;
  logic                aborted_q;
  logic [31:0]         remaining_q;
  logic [31:0]         position_q;
  logic [31:0]         rdata_q;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] half_q;
  logic [PERIOD_W-1:0] cnt_q;

  logic        wr_ctrl;
  logic        wr_steps;
  logic        wr_per;
  logic        wr_stat;
  logic        wr_pos;
  logic        busy;
  logic        abort_req;
  logic        start;
  logic        cnt_done;
  logic        done_set;
  logic        done_d;
  logic        aborted_d;
  logic        busy_d;
  logic [31:0] pos_step;
  logic [31:0] rdata_d;

  assign wr_ctrl  = avs_write && (avs_address == 3'd0);
  assign wr_steps = avs_write && (avs_address == 3'd1);
  assign wr_per   = avs_write && (avs_address == 3'd2);
  assign wr_stat  = avs_write && (avs_address == 3'd3);
  assign wr_pos   = avs_write && (avs_address == 3'd4);

  assign busy     = (state_q != IDLE);
  assign cnt_done = (cnt_q == '0);

  // Explicit abort bit, or dropping enable, kills a running move.
  assign abort_req = busy && wr_ctrl &&
                     (avs_writedata[2] || !avs_writedata[0]);

  assign start = !busy && wr_steps && ctrl_en_q &&
                 (avs_writedata != 32'd0);

  assign done_set = (state_q == LO) && cnt_done &&
                    (remaining_q == 32'd0) && !abort_req;

  // Set beats a simultaneous write-one-to-clear.
  assign done_d    = done_set ||
                     (done_q && !(wr_stat && avs_writedata[1]));
  assign aborted_d = abort_req ||
                     (aborted_q && !(wr_stat && avs_writedata[2]));
  assign busy_d    = start || (busy && !abort_req && !done_set);

  assign pos_step = dir_q ? position_q + 32'd1 : position_q - 32'd1;

  assign enable       = ~ctrl_en_q;
  assign dir          = dir_q;
  assign step         = step_q;
  assign avs_readdata = rdata_q;

  // Read mux; STATUS shows next-state flags so a same-cycle set is seen.
  always_comb begin
    rdata_d = '0;
    case (avs_address)
      3'd0:    rdata_d = {30'd0, ctrl_dir_q, ctrl_en_q};
      3'd1:    rdata_d = remaining_q;
      3'd2:    rdata_d = 32'(period_q);
      3'd3:    rdata_d = {29'd0, aborted_d, done_d, busy_d};
      3'd4:    rdata_d = position_q;
      default: rdata_d = '0;
    endcase
  end

  // Registered read data, latency one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (avs_read) begin
      rdata_q <= rdata_d;
    end
  end

  // Control/config registers and sticky status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_en_q  <= 1'b0;
      ctrl_dir_q <= 1'b0;
      period_q   <= PER_RST;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en_q <= avs_writedata[0];
        if (!busy) ctrl_dir_q <= avs_writedata[1];
      end
      if (wr_per && !busy) period_q <= avs_writedata[PERIOD_W-1:0];
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  // Move sequencer: setup hold, then half-period high/low pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      step_q      <= 1'b0;
      dir_q       <= 1'b0;
      remaining_q <= '0;
      position_q  <= '0;
      half_q      <= PER_MIN;
      cnt_q       <= '0;
    end else if (abort_req) begin
      state_q     <= IDLE;
      step_q      <= 1'b0;
      remaining_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          step_q <= 1'b0;
          dir_q  <= wr_ctrl ? avs_writedata[1] : ctrl_dir_q;
          if (wr_pos) position_q <= avs_writedata;
          if (start) begin
            remaining_q <= avs_writedata;
            half_q      <= (period_q < PER_MIN) ? PER_MIN : period_q;
            cnt_q       <= SETUP_LAST;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_done) begin
            state_q     <= HI;
            step_q      <= 1'b1;
            remaining_q <= remaining_q - 32'd1;
            position_q  <= pos_step;
            cnt_q       <= half_q - PERIOD_W'(1);
          end else begin
            cnt_q <= cnt_q - PERIOD_W'(1);
          end
        end
        HI: begin
          if (cnt_done) begin
            state_q <= LO;
            step_q  <= 1'b0;
            cnt_q   <= half_q - PERIOD_W'(1);
          end else begin
            cnt_q <= cnt_q - PERIOD_W'(1);
          end
        end
        LO: begin
          if (!cnt_done) begin
            cnt_q <= cnt_q - PERIOD_W'(1);
          end else if (remaining_q == 32'd0) begin
            state_q <= IDLE;
          end else begin
            state_q     <= HI;
            step_q      <= 1'b1;
            remaining_q <= remaining_q - 32'd1;
            position_q  <= pos_step;
            cnt_q       <= half_q - PERIOD_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_easy_driver_step_gen.sv
// tb_easy_driver_step_gen: directed + random moves against a
// waveform/position model derived from the register-level behaviour.
module tb_easy_driver_step_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        step;
  logic        dir;
  logic        enable;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] model_pos = '0;
  logic [31:0] v;

  easy_driver_step_gen dut (
    .clk           (clk),
    .reset         (reset),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .step          (step),
    .dir           (dir),
    .enable        (enable)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(posedge clk);
    #1 avs_write  = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_address = a;
    avs_read    = 1'b1;
    @(posedge clk);
    #1 avs_read = 1'b0;
    d = avs_readdata;
  endtask

  // Start a move of n steps and check every cycle of it against
  // the ideal waveform: 10 setup clocks, then n periods of 2*h clocks.
  task automatic run_move(input int per, input int n, input bit d);
    int h;
    int total;
    logic es;
    h = (per < 2) ? 2 : per;
    total = 10 + 2 * h * n;
    wr(3'd1, n);
    for (int j = 0; j <= total + 1; j++) begin
      @(negedge clk);
      es = (j >= 10) && (j < total) && (((j - 10) % (2 * h)) < h);
      chk($sformatf("step_c%0d", j), step, es);
      chk("dir", dir, d);
      chk("enable", enable, 0);
    end
    model_pos = d ? model_pos + n : model_pos - n;
  endtask

  initial begin
    reset = 1'b1;
    avs_address = '0;
    avs_write = 1'b0;
    avs_writedata = '0;
    avs_read = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", avs_readdata, 0);
    chk("rst_step", step, 0);
    chk("rst_enable", enable, 1);
    chk("rst_dir", dir, 0);
    @(negedge clk) reset = 1'b0;

    rd(3'd0, v); chk("rst_ctrl", v, 0);
    rd(3'd1, v); chk("rst_steps", v, 0);
    rd(3'd2, v); chk("rst_period", v, 2500);
    rd(3'd3, v); chk("rst_status", v, 0);
    rd(3'd4, v); chk("rst_pos", v, 0);
    rd(3'd5, v); chk("unmapped", v, 0);

    // 3 steps, dir=1, half=4; writes during the move must be ignored
    wr(3'd0, 3);
    wr(3'd2, 4);
    fork
      run_move(4, 3, 1'b1);
      begin
        repeat (15) @(posedge clk);
        wr(3'd1, 100);
        wr(3'd2, 9);
        wr(3'd4, 0);
      end
    join
    rd(3'd4, v); chk("t2_pos", v, model_pos);
    rd(3'd3, v); chk("t2_status", v, 2);
    rd(3'd1, v); chk("t2_steps", v, 0);
    rd(3'd2, v); chk("t3_period", v, 4);

    // abort after second rise
    wr(3'd3, 6);
    rd(3'd3, v); chk("w1c", v, 0);
    wr(3'd4, 0);
    model_pos = 0;
    wr(3'd0, 1);
    wr(3'd2, 3);
    wr(3'd1, 5);
    repeat (16) @(posedge clk);
    #1 chk("t4_rise2", step, 1);
    wr(3'd0, 5);
    chk("t4_abort_step", step, 0);
    chk("t4_enable", enable, 0);
    model_pos = 32'hFFFF_FFFE;
    rd(3'd4, v); chk("t4_pos", v, model_pos);
    rd(3'd3, v); chk("t4_status", v, 4);
    rd(3'd1, v); chk("t4_steps", v, 0);

    // PERIOD=0 clamps to half=2; no-op starts
    wr(3'd3, 6);
    wr(3'd0, 1);
    wr(3'd2, 0);
    run_move(0, 2, 1'b0);
    rd(3'd4, v); chk("t5_pos", v, model_pos);
    rd(3'd2, v); chk("t5_period", v, 0);
    wr(3'd3, 2);
    wr(3'd1, 0);
    rd(3'd3, v); chk("t5_zero_steps", v, 0);
    wr(3'd0, 0);
    chk("t5_enable_off", enable, 1);
    wr(3'd1, 5);
    rd(3'd3, v); chk("t5_en0_busy", v, 0);
    rd(3'd1, v); chk("t5_en0_steps", v, 0);

    // random moves
    for (int k = 0; k < 5; k++) begin
      bit d;
      int per;
      int n;
      d   = 1'($urandom % 2);
      per = int'($urandom_range(0, 5));
      n   = int'($urandom_range(1, 4));
      wr(3'd3, 6);
      wr(3'd0, d ? 3 : 1);
      wr(3'd2, per);
      run_move(per, n, d);
      rd(3'd4, v); chk($sformatf("rnd%0d_pos", k), v, model_pos);
      rd(3'd3, v); chk($sformatf("rnd%0d_status", k), v, 2);
    end

    // wrap, plus STATUS read on the cycle done sets
    wr(3'd3, 6);
    wr(3'd0, 3);
    wr(3'd4, 32'h7FFF_FFFF);
    wr(3'd2, 2);
    wr(3'd1, 1);
    repeat (13) @(posedge clk);
    rd(3'd3, v); chk("t6_status_same_cycle", v, 2);
    rd(3'd4, v); chk("t6_wrap", v, 32'h8000_0000);

    // async reset in the middle of a high phase
    wr(3'd0, 3);
    wr(3'd2, 4);
    wr(3'd1, 5);
    repeat (11) @(posedge clk);
    #1 chk("t1_in_hi", step, 1);
    reset = 1'b1;
    #1;
    chk("t1_step", step, 0);
    chk("t1_enable", enable, 1);
    chk("t1_dir", dir, 0);
    chk("t1_rdata", avs_readdata, 0);
    @(negedge clk) reset = 1'b0;
    rd(3'd0, v); chk("t1_ctrl", v, 0);
    rd(3'd1, v); chk("t1_steps", v, 0);
    rd(3'd2, v); chk("t1_period", v, 2500);
    rd(3'd3, v); chk("t1_status", v, 0);
    rd(3'd4, v); chk("t1_pos", v, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
